dec_sched: RTL and testbench

DEC_SCHED -- requirements
Module: dec_sched

---
 rtl/dec_sched_pkg.sv | 16 +
 rtl/dec_sched_dec.sv | 17 +
 rtl/dec_sched.sv | 143 ++++++++++++++
 tb/tb_dec_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_sched_pkg.sv
// dec_sched_pkg: shared state encoding and requester ids for the countdown scheduler.
package dec_sched_pkg;

   localparam int unsigned DEC_SCHED_WIDTH = 16;

   // Scheduler states: one countdown in flight at a time
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic REQ_ID0 = 1'b0;
   localparam logic REQ_ID1 = 1'b1;

endpackage : dec_sched_pkg

// File: rtl/dec_sched_dec.sv
// dec_sched_dec: shared saturating decrement datapath (never goes below zero).
module dec_sched_dec #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH-1:0] y_o
);

   // Decrement by one, holding at zero
   always_comb begin
      y_o = '0;
      if (a_i != '0) begin
         y_o = a_i - WIDTH'(1);
      end
   end

endmodule : dec_sched_dec

// File: rtl/dec_sched.sv
// dec_sched: two-requester round-robin scheduler sharing one countdown datapath.
// Optional abort input enabled by defining DEC_SCHED_ABORT_EN.
module dec_sched
   import dec_sched_pkg::*;
#(
   parameter int unsigned WIDTH = DEC_SCHED_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_i,
   input  logic [WIDTH-1:0] a0_i,
   input  logic             req1_i,
   input  logic [WIDTH-1:0] a1_i,
`ifdef DEC_SCHED_ABORT_EN
   input  logic             abort_i,
`endif
   output logic             gnt0_o,
   output logic             gnt1_o,
   output logic [WIDTH-1:0] cnt_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             done_id_o
);

   state_e           state_q;
   logic [WIDTH-1:0] cnt_q;
   logic             owner_q;
   logic             ptr_q;
   logic             busy_q;
   logic             done_q;
   logic             done_id_q;

   logic             gnt0_c;
   logic             gnt1_c;
   logic             abort_c;
   logic [WIDTH-1:0] dec_y;
   logic [WIDTH-1:0] load_d;
   logic             owner_d;

`ifdef DEC_SCHED_ABORT_EN
   assign abort_c = abort_i;
`else
   assign abort_c = 1'b0;
`endif

   // Round-robin arbitration, only while idle; sole requester always wins
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (state_q == ST_IDLE) begin
         if (req0_i && req1_i) begin
            if (ptr_q == REQ_ID0) begin
               gnt0_c = 1'b1;
            end else begin
               gnt1_c = 1'b1;
            end
         end else if (req0_i) begin
            gnt0_c = 1'b1;
         end else if (req1_i) begin
            gnt1_c = 1'b1;
         end
      end
   end

   // Select the winner's start value and id
   always_comb begin
      owner_d = gnt1_c ? REQ_ID1 : REQ_ID0;
      load_d  = gnt1_c ? a1_i : a0_i;
   end

   dec_sched_dec #(
      .WIDTH (WIDTH)
   ) u_dec (
      .a_i (cnt_q),
      .y_o (dec_y)
   );

   // Scheduler FSM with registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         owner_q   <= REQ_ID0;
         ptr_q     <= REQ_ID0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (gnt0_c || gnt1_c) begin
                  owner_q <= owner_d;
                  ptr_q   <= ~owner_d;
                  cnt_q   <= load_d;
                  busy_q  <= 1'b1;
                  if (load_d == '0) begin
                     state_q   <= ST_DONE;
                     done_q    <= 1'b1;
                     done_id_q <= owner_d;
                  end else begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (abort_c) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= dec_y;
                  if (dec_y == '0) begin
                     state_q   <= ST_DONE;
                     done_q    <= 1'b1;
                     done_id_q <= owner_q;
                  end
               end
            end
            ST_DONE: begin
               state_q   <= ST_IDLE;
               cnt_q     <= '0;
               busy_q    <= 1'b0;
               done_id_q <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Grants are combinational and suppressed while reset is asserted
   assign gnt0_o    = gnt0_c & rst_n;
   assign gnt1_o    = gnt1_c & rst_n;
   assign cnt_o     = cnt_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign done_id_o = done_id_q;

endmodule : dec_sched

// File: tb/tb_dec_sched.sv
// tb_dec_sched: table-driven cycle vectors plus a done-event scoreboard for dec_sched.
module tb_dec_sched;

   localparam int unsigned W = 16;

   logic         clk;
   logic         rst_n;
   logic         req0, req1;
   logic [W-1:0] a0, a1;
   logic         gnt0_o, gnt1_o, busy_o, done_o, done_id_o;
   logic [W-1:0] cnt_o;
`ifdef DEC_SCHED_ABORT_EN
   logic         abort;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit sb_en = 0;

   typedef struct {
      logic id;
      int   cyc;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic         r0;
      logic [W-1:0] a0;
      logic         r1;
      logic [W-1:0] a1;
      logic [20:0]  exp;   // {gnt0, gnt1, busy, done, done_id, cnt}
   } vec_t;
   vec_t vt[22];

   dec_sched #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_i    (req0),
      .a0_i      (a0),
      .req1_i    (req1),
      .a1_i      (a1),
`ifdef DEC_SCHED_ABORT_EN
      .abort_i   (abort),
`endif
      .gnt0_o    (gnt0_o),
      .gnt1_o    (gnt1_o),
      .cnt_o     (cnt_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .done_id_o (done_id_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic vec_t mk(input logic r0, input logic [W-1:0] x0,
                               input logic r1, input logic [W-1:0] x1,
                               input logic g0, input logic g1, input logic bz,
                               input logic dn, input logic id, input logic [W-1:0] c);
      vec_t v;
      v.r0 = r0; v.a0 = x0; v.r1 = r1; v.a1 = x1;
      v.exp = {g0, g1, bz, dn, id, c};
      return v;
   endfunction

   function automatic logic [20:0] outs();
      return {gnt0_o, gnt1_o, busy_o, done_o, done_id_o, cnt_o};
   endfunction

   // Scoreboard monitor: every Done must match a queued job; consecutive busy cycles count down by one
   logic         prev_busy = 1'b0;
   logic [W-1:0] prev_cnt  = '0;
   always @(negedge clk) begin
      sb_t e;
      #1;
      if (sb_en) begin
         if (done_o) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_done: cycle %0d id %0d, required no Done", cyc, done_id_o);
            end else begin
               e = sb_q.pop_front();
               if (e.id !== done_id_o || e.cyc != cyc || cnt_o !== '0) begin
                  n_errors++;
                  $display("FAIL done_event: got id %0d cycle %0d cnt %0d, required id %0d cycle %0d cnt 0",
                           done_id_o, cyc, cnt_o, e.id, e.cyc);
               end
            end
         end
         if (prev_busy && busy_o) begin
            n_checks++;
            if (cnt_o !== W'(prev_cnt - W'(1))) begin
               n_errors++;
               $display("FAIL countdown_step: cycle %0d cnt %0d, required %0d", cyc, cnt_o, W'(prev_cnt - W'(1)));
            end
         end
      end
      prev_busy = busy_o;
      prev_cnt  = cnt_o;
   end

   // Issue one request, wait for its grant, optionally queue the expected Done
   task automatic run_job(input logic id, input logic [W-1:0] n, input bit expect_done);
      bit got;
      got = 0;
      @(negedge clk);
      if (id) begin req1 = 1'b1; a1 = n; end
      else    begin req0 = 1'b1; a0 = n; end
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         if ((id ? gnt1_o : gnt0_o) === 1'b1) begin
            got = 1;
            if (expect_done) sb_q.push_back('{id: id, cyc: cyc + int'(n) + 1});
         end else begin
            @(negedge clk);
         end
      end
      n_checks++;
      if (!got) begin
         n_errors++;
         $display("FAIL grant_timeout: no grant for id %0d, required a grant", id);
      end
      @(negedge clk);
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   // Wait until the scheduler is idle and all expected Done events have arrived
   task automatic wait_quiet(input int limit);
      bit ok;
      ok = 0;
      for (int k = 0; k < limit && !ok; k++) begin
         @(negedge clk);
         #2;
         if (!busy_o && sb_q.size() == 0) ok = 1;
      end
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL quiet_timeout: busy %0d pending %0d, required idle with none pending", busy_o, sb_q.size());
      end
   endtask

   initial begin
      req0 = 1'b0; req1 = 1'b0; a0 = '0; a1 = '0;
`ifdef DEC_SCHED_ABORT_EN
      abort = 1'b0;
`endif
      rst_n = 1'b0;

      //           r0 a0      r1 a1      g0 g1 bz dn id cnt
      vt[0]  = mk(1, 16'd3, 0, 16'd0,  1, 0, 0, 0, 0, 16'd0);
      vt[1]  = mk(0, 16'd0, 0, 16'd0,  0, 0, 1, 0, 0, 16'd3);
      vt[2]  = mk(0, 16'd0, 0, 16'd0,  0, 0, 1, 0, 0, 16'd2);
      vt[3]  = mk(0, 16'd0, 0, 16'd0,  0, 0, 1, 0, 0, 16'd1);
      vt[4]  = mk(0, 16'd0, 0, 16'd0,  0, 0, 1, 1, 0, 16'd0);
      vt[5]  = mk(0, 16'd0, 0, 16'd0,  0, 0, 0, 0, 0, 16'd0);
      vt[6]  = mk(0, 16'd0, 1, 16'd0,  0, 1, 0, 0, 0, 16'd0);
      vt[7]  = mk(0, 16'd0, 0, 16'd0,  0, 0, 1, 1, 1, 16'd0);
      vt[8]  = mk(0, 16'd0, 0, 16'd0,  0, 0, 0, 0, 0, 16'd0);
      vt[9]  = mk(1, 16'd1, 1, 16'd2,  1, 0, 0, 0, 0, 16'd0);
      vt[10] = mk(0, 16'd0, 1, 16'd2,  0, 0, 1, 0, 0, 16'd1);
      vt[11] = mk(0, 16'd0, 1, 16'd2,  0, 0, 1, 1, 0, 16'd0);
      vt[12] = mk(0, 16'd0, 1, 16'd2,  0, 1, 0, 0, 0, 16'd0);
      vt[13] = mk(0, 16'd0, 0, 16'd0,  0, 0, 1, 0, 0, 16'd2);
      vt[14] = mk(0, 16'd0, 0, 16'd0,  0, 0, 1, 0, 0, 16'd1);
      vt[15] = mk(0, 16'd0, 0, 16'd0,  0, 0, 1, 1, 1, 16'd0);
      vt[16] = mk(0, 16'd0, 0, 16'd0,  0, 0, 0, 0, 0, 16'd0);
      vt[17] = mk(1, 16'd0, 0, 16'd0,  1, 0, 0, 0, 0, 16'd0);
      vt[18] = mk(0, 16'd0, 0, 16'd0,  0, 0, 1, 1, 0, 16'd0);
      vt[19] = mk(1, 16'd0, 1, 16'd0,  0, 1, 0, 0, 0, 16'd0);
      vt[20] = mk(0, 16'd0, 0, 16'd0,  0, 0, 1, 1, 1, 16'd0);
      vt[21] = mk(0, 16'd0, 0, 16'd0,  0, 0, 0, 0, 0, 16'd0);

      // Reset state, with a request held high to confirm no grant leaks out
      repeat (2) @(negedge clk);
      req0 = 1'b1; a0 = 16'd5;
      #1;
      n_checks++;
      if (outs() !== 21'd0) begin
         n_errors++;
         $display("FAIL reset_state: got %h, required 0", outs());
      end
      req0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Cycle-accurate vector table
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         req0 = vt[i].r0; a0 = vt[i].a0; req1 = vt[i].r1; a1 = vt[i].a1;
         #1;
         n_checks++;
         if (outs() !== vt[i].exp) begin
            n_errors++;
            $display("FAIL vec_%0d: got {g0,g1,busy,done,id,cnt}=%h, required %h", i, outs(), vt[i].exp);
         end
      end
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;

      // Scoreboarded jobs with assorted start values and requesters
      sb_en = 1;
      for (int j = 0; j < 6; j++) begin
         run_job(1'($urandom_range(0, 1)), W'($urandom_range(0, 9)), 1);
         wait_quiet(40);
      end

      // Reset in the middle of a long countdown: nothing completes
      run_job(1'b0, 16'h00AB, 0);
      repeat (5) @(negedge clk);
      req0 = 1'b1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (outs() !== 21'd0) begin
         n_errors++;
         $display("FAIL reset_mid_run: got %h, required 0", outs());
      end
      @(negedge clk);
      req0 = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run_job(1'b1, 16'd4, 1);
      wait_quiet(40);

`ifdef DEC_SCHED_ABORT_EN
      // Abort on the third RUN cycle drops the job without Done
      run_job(1'b0, 16'h0010, 0);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      #1;
      n_checks++;
      if (cnt_o !== 16'd14 || busy_o !== 1'b1) begin
         n_errors++;
         $display("FAIL abort_pre: cnt %0d busy %0d, required cnt 14 busy 1", cnt_o, busy_o);
      end
      @(negedge clk);
      abort = 1'b0;
      #1;
      n_checks++;
      if (cnt_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_post: cnt %0d busy %0d done %0d, required all 0", cnt_o, busy_o, done_o);
      end
      wait_quiet(10);
`endif

      // Maximum start value counts all the way down without wrapping
      run_job(1'b0, 16'hFFFF, 1);
      wait_quiet(70000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_dec_sched
